ext_obi_slave_arbiter: RTL and testbench

- Round-robin arbiter that shares the single external slow-memory OBI slave among the external-crossbar masters (NMASTER=5, including the USB-to-HEEP bridge port).
- Sits between the testharness external master ports and the slow memory.
- Holds each selection stable until the slave grants it, as OBI requires.
- Tracks in-flight transactions in an ID FIFO so that each response returns to the master that issued the request.

---
 rtl/ext_obi_slave_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ext_obi_slave_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_obi_slave_arbiter.sv
// rtl/ext_obi_slave_arbiter.sv - round-robin OBI arbiter sharing one slow-memory slave among external masters
module ext_obi_slave_arbiter #(
    parameter int NMASTER         = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NMASTER-1:0]                   m_req_i,
    input  logic [NMASTER-1:0]                   m_we_i,
    input  logic [NMASTER*(DATA_W/8)-1:0]        m_be_i,
    input  logic [NMASTER*ADDR_W-1:0]            m_addr_i,
    input  logic [NMASTER*DATA_W-1:0]            m_wdata_i,
    output logic [NMASTER-1:0]                   m_gnt_o,
    output logic [NMASTER-1:0]                   m_rvalid_o,
    output logic [DATA_W-1:0]                    m_rdata_o,
    output logic                                 s_req_o,
    output logic                                 s_we_o,
    output logic [DATA_W/8-1:0]                  s_be_o,
    output logic [ADDR_W-1:0]                    s_addr_o,
    output logic [DATA_W-1:0]                    s_wdata_o,
    input  logic                                 s_gnt_i,
    input  logic                                 s_rvalid_i,
    input  logic [DATA_W-1:0]                    s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SEL_W = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_rr_sel;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_sel;
    logic             w_sel_valid;
    logic [SEL_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic             w_full;
    logic             w_empty;
    logic             w_req;
    logic             w_gnt;
    logic             w_pop;
    logic [SEL_W-1:0] w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin pick: lowest requester at/after the pointer wins, else lowest below it
    always_comb begin
        w_rr_sel   = r_ptr;
        w_rr_valid = 1'b0;
        for (int k = NMASTER - 1; k >= 0; k--) begin
            if (m_req_i[k] && (k < int'(r_ptr))) begin
                w_rr_sel   = SEL_W'(k);
                w_rr_valid = 1'b1;
            end
        end
        for (int k = NMASTER - 1; k >= 0; k--) begin
            if (m_req_i[k] && (k >= int'(r_ptr))) begin
                w_rr_sel   = SEL_W'(k);
                w_rr_valid = 1'b1;
            end
        end
    end

    // An ungranted request keeps its registered master until the slave accepts it
    assign w_sel       = (r_state == S_LOCKED) ? r_sel : w_rr_sel;
    assign w_sel_valid = (r_state == S_LOCKED) | w_rr_valid;

    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_req   = rst_ni & w_sel_valid & ~w_full;
    assign w_gnt   = w_req & s_gnt_i;
    assign w_pop   = rst_ni & s_rvalid_i & ~w_empty;
    assign w_head  = r_fifo[r_rd_ptr];

    assign s_req_o       = w_req;
    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = rst_ni ? r_count : '0;
    assign err_o         = r_err;

    // Request fields, grant and response routing muxed by master index
    always_comb begin
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        for (int k = 0; k < NMASTER; k++) begin
            if (w_sel == SEL_W'(k)) begin
                s_we_o    = m_we_i[k];
                s_be_o    = m_be_i[k*BE_W +: BE_W];
                s_addr_o  = m_addr_i[k*ADDR_W +: ADDR_W];
                s_wdata_o = m_wdata_i[k*DATA_W +: DATA_W];
                m_gnt_o[k] = w_gnt;
            end
            if (w_head == SEL_W'(k)) begin
                m_rvalid_o[k] = w_pop;
            end
        end
    end

    // Lock state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lock on an unanswered request, release on the slave grant
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req && !s_gnt_i) w_state_next = S_LOCKED;
            S_LOCKED: if (s_gnt_i) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Held selection and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sel <= '0;
            r_ptr <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_req && !s_gnt_i) begin
                r_sel <= w_sel;
            end
            if (w_gnt) begin
                r_ptr <= (w_sel == SEL_W'(NMASTER - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    // ID FIFO storage; contents are meaningless while the count says empty
    always_ff @(posedge clk_i) begin
        if (w_gnt) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

    // ID FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_gnt) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_gnt, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a response nobody is waiting for
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (s_rvalid_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ext_obi_slave_arbiter.sv
// tb/tb_ext_obi_slave_arbiter.sv - self-checking bench for ext_obi_slave_arbiter
module tb_ext_obi_slave_arbiter;

    localparam int N  = 5;
    localparam int MO = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk;
    logic            rst_ni;
    logic [N-1:0]    m_req_i;
    logic [N-1:0]    m_we_i;
    logic [N*BW-1:0] m_be_i;
    logic [N*AW-1:0] m_addr_i;
    logic [N*DW-1:0] m_wdata_i;
    logic [N-1:0]    m_gnt_o;
    logic [N-1:0]    m_rvalid_o;
    logic [DW-1:0]   m_rdata_o;
    logic            s_req_o;
    logic            s_we_o;
    logic [BW-1:0]   s_be_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW-1:0]   s_wdata_o;
    logic            s_gnt_i;
    logic            s_rvalid_i;
    logic [DW-1:0]   s_rdata_i;
    logic [1:0]      outstanding_o;
    logic            err_o;

    ext_obi_slave_arbiter #(
        .NMASTER(N), .MAX_OUTSTANDING(MO), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pointer, pending (ungranted) master or -1, queue of in-flight masters
    int     mptr = 0;
    int     mpend = -1;
    int     mq[$];
    bit     merr = 1'b0;
    int     e_sel;
    bit     e_sreq;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        bit valid;
        if (!rst_ni) begin
            chk("rst_sreq", 64'(s_req_o), 64'(0));
            chk("rst_gnt", 64'(m_gnt_o), 64'(0));
            chk("rst_rvalid", 64'(m_rvalid_o), 64'(0));
            chk("rst_outst", 64'(outstanding_o), 64'(0));
            e_sreq = 1'b0;
            e_gnt  = '0;
            return;
        end
        valid = 1'b0;
        e_sel = 0;
        if (mpend >= 0) begin
            e_sel = mpend;
            valid = 1'b1;
        end else begin
            for (int j = 0; j < N; j++) begin
                int m;
                m = (mptr + j) % N;
                if (!valid && m_req_i[m]) begin
                    e_sel = m;
                    valid = 1'b1;
                end
            end
        end
        e_sreq = valid && (mq.size() < MO);
        e_gnt  = (e_sreq && s_gnt_i) ? N'(1) << e_sel : '0;
        e_rv   = (s_rvalid_i && mq.size() > 0) ? N'(1) << mq[0] : '0;
        chk("sreq", 64'(s_req_o), 64'(e_sreq));
        chk("gnt", 64'(m_gnt_o), 64'(e_gnt));
        chk("rvalid", 64'(m_rvalid_o), 64'(e_rv));
        chk("outst", 64'(outstanding_o), 64'(mq.size()));
        chk("err", 64'(err_o), 64'(merr));
        if (e_sreq) begin
            chk("addr", 64'(s_addr_o), 64'(m_addr_i[e_sel*AW +: AW]));
            chk("wdata", 64'(s_wdata_o), 64'(m_wdata_i[e_sel*DW +: DW]));
            chk("be", 64'(s_be_o), 64'(m_be_i[e_sel*BW +: BW]));
            chk("we", 64'(s_we_o), 64'(m_we_i[e_sel]));
        end
        if (e_rv != 0) chk("rdata", 64'(m_rdata_o), 64'(s_rdata_i));
    endtask

    task automatic model_update();
        if (!rst_ni) begin
            mptr  = 0;
            mpend = -1;
            mq.delete();
            merr  = 1'b0;
            return;
        end
        if (s_rvalid_i) begin
            if (mq.size() == 0) merr = 1'b1;
            else void'(mq.pop_front());
        end
        if (e_gnt != 0) begin
            mq.push_back(e_sel);
            mptr = (e_sel + 1) % N;
        end
        mpend = (e_sreq && !s_gnt_i) ? e_sel : -1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drain();
        m_req_i    = '0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (mq.size() > 0) step();
        end
        s_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        m_req_i    = 5'b11111;
        m_we_i     = 5'b10101;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = 32'h0;
        for (int k = 0; k < N; k++) begin
            m_addr_i[k*AW +: AW]  = 32'h1000_0000 + 32'(k * 16);
            m_wdata_i[k*DW +: DW] = 32'hD000_0000 + 32'(k);
            m_be_i[k*BW +: BW]    = 4'(k + 1);
        end

        // Reset held three cycles with everyone requesting
        for (int i = 0; i < 3; i++) step();
        rst_ni = 1'b1;

        // All masters requesting, slave grants every cycle, response one cycle later
        s_gnt_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_rvalid_i = (i > 0);
            s_rdata_i  = $urandom;
            settle();
            chk("rr_order", 64'(m_gnt_o), 64'(N'(1) << (i % N)));
            advance();
        end
        drain();

        // Master 2 held while the slave stalls, even when master 0 joins
        m_addr_i[2*AW +: AW] = 32'h0000_0100;
        m_req_i = 5'b00100;
        s_gnt_i = 1'b0;
        step();
        m_req_i = 5'b00101;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lock_addr", 64'(s_addr_o), 64'h100);
            advance();
        end
        s_gnt_i = 1'b1;
        settle();
        chk("lock_gnt", 64'(m_gnt_o), 64'b00100);
        advance();
        drain();

        // Fill the FIFO (masters 3 and 4), then release with one response
        m_req_i = 5'b11111;
        s_gnt_i = 1'b1;
        step();
        step();
        settle();
        chk("full_outst", 64'(outstanding_o), 64'd2);
        chk("full_sreq", 64'(s_req_o), 64'd0);
        advance();
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hCAFE_0001;
        settle();
        chk("full_rv_m3", 64'(m_rvalid_o), 64'b01000);
        chk("full_rdata", 64'(m_rdata_o), 64'hCAFE_0001);
        advance();
        s_rvalid_i = 1'b0;
        settle();
        chk("full_reassert", 64'(s_req_o), 64'd1);
        advance();
        drain();

        // Grant to master 3 in the same cycle as the response to master 1
        m_req_i = 5'b00010;
        s_gnt_i = 1'b1;
        step();
        m_req_i    = 5'b01000;
        s_rvalid_i = 1'b1;
        settle();
        chk("sim_gnt", 64'(m_gnt_o), 64'b01000);
        chk("sim_rv", 64'(m_rvalid_o), 64'b00010);
        advance();
        m_req_i    = '0;
        s_rvalid_i = 1'b0;
        settle();
        chk("sim_outst", 64'(outstanding_o), 64'd1);
        advance();
        drain();

        // Response with nothing outstanding sets the sticky error
        s_rvalid_i = 1'b1;
        settle();
        chk("orphan_rv", 64'(m_rvalid_o), 64'd0);
        advance();
        s_rvalid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("err_sticky", 64'(err_o), 64'd1);
            advance();
        end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        settle();
        chk("err_cleared", 64'(err_o), 64'd0);
        advance();

        // Reset mid-transaction, then a late response
        m_req_i = 5'b00001;
        s_gnt_i = 1'b1;
        step();
        rst_ni = 1'b0;
        step();
        rst_ni     = 1'b1;
        m_req_i    = '0;
        s_rvalid_i = 1'b1;
        step();
        s_rvalid_i = 1'b0;
        settle();
        chk("late_rsp_err", 64'(err_o), 64'd1);
        advance();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_ni     = ($urandom_range(0, 99) != 0);
            m_req_i    = N'($urandom);
            m_we_i     = N'($urandom);
            m_be_i     = (N*BW)'({$urandom, $urandom});
            for (int k = 0; k < N; k++) begin
                m_addr_i[k*AW +: AW]  = $urandom;
                m_wdata_i[k*DW +: DW] = $urandom;
            end
            s_gnt_i    = ($urandom_range(0, 2) != 0);
            s_rvalid_i = (mq.size() > 0) ? ($urandom_range(0, 1) == 1)
                                         : ($urandom_range(0, 15) == 0);
            s_rdata_i  = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
